// File: rtl/add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key
// Description : AES AddRoundKey stage placed after mixColumns. Each accepted
//               128-bit state beat is XORed with the round key picked by an
//               internal round counter. Round keys live in a local bank of
//               NR+1 registers loaded through a write port. A single output
//               register with a valid/ready handshake lets the stage stall
//               against its consumer without dropping data.
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               key_wr_en/addr/data - key bank write port (addr > NR ignored)
//               start             - restart the round counter at 0
//               in_valid/in_ready - input handshake, state_in payload
//               out_valid/out_ready - output handshake, state_out payload
//               round_out         - round index applied to state_out
//               last_round        - high with out_valid when round_out == NR
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_wr_en,
    input  logic [3:0]   key_wr_addr,
    input  logic [127:0] key_wr_data,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_out,
    output logic         last_round
);

    localparam logic [3:0] C_NR_IDX = 4'(NR);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [127:0]   key_q [0:NR];
    logic [3:0]     rnd_q;
    logic [3:0]     rnd_d;
    logic [127:0]   state_out_q;
    logic [3:0]     round_out_q;
    logic           last_q;

    logic           w_out_valid;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_key_wr_ok;
    logic [3:0]     w_eff_idx;
    logic [127:0]   w_key_sel;

    assign w_out_valid = (state_q == S_FULL);
    assign w_in_ready  = !w_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    assign w_key_wr_ok = key_wr_en && (key_wr_addr <= C_NR_IDX);

    // start forces round 0 for the beat presented in the same cycle.
    assign w_eff_idx   = start ? 4'd0 : rnd_q;

    // Registered bank: a read in the write cycle sees the previous key.
    assign w_key_sel   = key_q[w_eff_idx];

    // ------------------------------------------------------------------------
    // Key bank
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                key_q[i] <= '0;
            end
        end else if (w_key_wr_ok) begin
            key_q[key_wr_addr] <= key_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Round counter next state
    // ------------------------------------------------------------------------
    always_comb begin
        rnd_d = rnd_q;
        if (w_accept) begin
            rnd_d = (w_eff_idx == C_NR_IDX) ? 4'd0 : (w_eff_idx + 4'd1);
        end else if (start) begin
            rnd_d = 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Output register occupancy FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                // Drain and refill in one cycle keeps the register full.
                if (w_accept) begin
                    state_d = S_FULL;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // Data lines only change on an accepted beat; they hold after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_out_q <= '0;
            round_out_q <= 4'd0;
            last_q      <= 1'b0;
        end else if (w_accept) begin
            state_out_q <= state_in ^ w_key_sel;
            round_out_q <= w_eff_idx;
            last_q      <= (w_eff_idx == C_NR_IDX);
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign state_out  = state_out_q;
    assign round_out  = round_out_q;
    assign last_round = last_q && w_out_valid;

endmodule
`default_nettype wire

// File: doc/add_round_key.md
# add_round_key

AddRoundKey stage that sits directly downstream of `mixColumns` in the AES datapath. It XORs each 128-bit state beat with the round key selected by an internal round counter. Round keys come from an on-block key bank loaded through a write port. A valid/ready handshake with a single output register lets the stage stall against its consumer without losing data.

## Interface
- `NR`, default 10: number of AES rounds. The key bank holds NR+1 keys (indices 0..NR).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `key_wr_en`  input  1  write strobe for the key bank.
- `key_wr_addr`  input  4  key index, 0..NR; writes with an address above NR are ignored.
- `key_wr_data`  input  128  round key, same byte packing as the state.
- `start`  input  1  begin a new block: round counter restarts at 0.
- `in_valid`  input  1  `state_in` is valid.
- `in_ready`  output  1  stage can accept `state_in` this cycle.
- `state_in`  input  128  state from `mixColumns` (or the plaintext for round 0). Byte 0 is at [127:120].
- `out_valid`  output  1  `state_out` holds a result.
- `out_ready`  input  1  consumer accepts `state_out` this cycle.
- `state_out`  output  128  state_in XOR key[round].
- `round_out`  output  4  round index applied to the current `state_out`.
- `last_round`  output  1  high with `out_valid` when `round_out` == NR.

## Operation
- Key bank:
  - NR+1 registers of 128 bits, written synchronously when `key_wr_en` is high and `key_wr_addr` ≤ NR.
  - A lookup in the same cycle as a write to the same index returns the old key. The new key is used from the next cycle.
- Round counter `rnd`:
  - 4 bits, reset value 0.
  - On an input handshake (`in_valid` && `in_ready`) the beat uses key[rnd]. `rnd` then becomes rnd+1, or wraps to 0 when rnd == NR.
  - `start` high sets the effective index to 0 for this cycle:
    - With a handshake in the same cycle: the beat uses key[0], and `rnd` becomes 1.
    - Without a handshake: `rnd` becomes 0.
- Datapath: a plain bitwise XOR, so byte order does not matter. No carry and no width growth.
- Output register:
  - `in_ready` = !out_valid || out_ready, which is combinational from `out_ready`.
  - On a handshake, load `state_out`, `round_out` and `last_round`, and set `out_valid`.
  - When out_valid && out_ready and there is no new input, clear `out_valid`. Data lines hold their last value.
  - Simultaneous output drain and input accept: the register is reloaded and `out_valid` stays high. Full throughput is one beat per cycle.
  - While out_valid && !out_ready: `in_ready` = 0, and the outputs and `rnd` hold.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on an input handshake.
  - FULL→EMPTY on an output handshake with no input.
  - FULL→FULL on a stall, or on drain plus accept in the same cycle.

## Timing
- Reset (async assert; deassert sampled on `clk`):
  - `out_valid`=0, `state_out`=0, `round_out`=0, `last_round`=0, `rnd`=0, all key registers=0.
  - `in_ready` reads 1 while in reset.
- Latency: 1 cycle. A beat accepted at edge N is on `state_out` after edge N, while `out_valid` is high.
- Reset mid-block: in-flight data is discarded and the keys are cleared. The bank must be reloaded before new traffic.
- `start` while FULL and stalled: takes effect only on the next accepted beat, which uses key[0]. The held output is unchanged.
- `out_ready` may toggle freely. The output is stable from the cycle `out_valid` rises until the handshake completes.

## Test plan
- FIPS-197 round 0:
  - Stimulus: key[0]=2b7e151628aed2a6abf7158809cf4f3c; pulse `start` together with `state_in`=3243f6a8885a308d313198a2e0370734.
  - Required: `state_out`=193de3bea0f4e22b9ac68d2ae9f84808, `round_out`=0, `last_round`=0.
- FIPS-197 round 1:
  - Stimulus: next beat 046681e5e0cb199a48f8d37a2806264c with key[1]=a0fafe1788542cb123a339392a6c7605.
  - Required: `state_out`=a49c7ff2689f352b6b5bea43026a5049, `round_out`=1.
- Wrap-around:
  - Stimulus: 11 back-to-back beats with `out_ready`=1.
  - Required: one output per cycle; `round_out` runs 0..10; `last_round` only on beat 10; a 12th beat gets `round_out`=0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - Required: `in_ready`=0, outputs and `rnd` frozen. Release: each beat appears exactly once, in order.
- Key write collision:
  - Stimulus: write key[2]=ffff…ff in the same cycle a beat with `state_in`=0 is accepted at round 2 (old key[2]=0).
  - Required: `state_out`=0. The same beat after the next `start` cycle yields ff…ff. A write with `key_wr_addr`=11 leaves the bank unchanged.
- Async reset mid-stream:
  - Stimulus: assert `rst` between edges while FULL.
  - Required: `out_valid` drops immediately; `round_out`=0; a subsequent beat with `start` uses the cleared key[0]=0, so `state_out`=`state_in`.
